i2c_xfer_sequencer: RTL and testbench
=====================================

I2C_XFER_SEQUENCER -- requirements
Module: i2c_xfer_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'h0063, prescale value written to PRERhi/PRERlo (100 kHz SCL at 50 MHz).
REQ-002 SHALL have parameter CTR_VAL, default 8'h80, value written to CTR (EN=1, IEN=0).
REQ-003 SHALL have port CLOCK_50  in  1  clock; all logic rising-edge.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  2  per-requester transaction request, held until req_ready.
REQ-006 SHALL have port req_ready  out  2  one-cycle accept pulse, one-hot.
REQ-007 SHALL have ports req_rnw (in 2), req_dev (in 2x7), req_reg (in 2x8), req_wdata (in 2x8): read flag, 7-bit slave address, register index, and write byte, per requester.
REQ-008 SHALL have port rsp_valid  out  2  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have ports rsp_nack (out 1) and rsp_rdata (out 8), valid only with rsp_valid.
REQ-010 SHALL have port busy  out  1  high from grant to rsp_valid inclusive, and during init.
REQ-011 SHALL have Wishbone master ports wb_adr_o (out 3), wb_dat_o (out 8), wb_we_o, wb_stb_o, wb_cyc_o (out 1 each), wb_dat_i (in 8), wb_ack_i (in 1).

Function
REQ-012 SHALL run each core access as a single WB cycle: drive adr/dat/we with stb=cyc=1, hold until wb_ack_i, then deassert stb/cyc on the next edge with at least one idle cycle before the next access.
REQ-013 SHALL capture wb_dat_i on the ack cycle of read accesses.
REQ-014 SHALL, after reset, write PRERlo=PRESCALE[7:0] (adr 0), PRERhi=PRESCALE[15:8] (adr 1), then CTR=CTR_VAL (adr 2), then enter IDLE; no request is granted before this.
REQ-015 SHALL arbitrate in IDLE round-robin: with one requester valid, grant it; with both valid, grant the one not granted last; after reset, requester 0 wins a tie.
REQ-016 SHALL latch rnw/dev/reg/wdata on the grant cycle and pulse req_ready on that cycle.
REQ-017 SHALL perform writes as: TXR(adr 3)={dev,0}; CR(adr 4)=8'h90; POLL; TXR=reg; CR=8'h10; POLL; TXR=wdata; CR=8'h50; POLL; respond.
REQ-018 SHALL perform reads as: TXR={dev,0}; CR=8'h90; POLL; TXR=reg; CR=8'h10; POLL; TXR={dev,1}; CR=8'h90; POLL; CR=8'h68 (RD|ACK|STO); POLL; read RXR (adr 3); respond with rsp_rdata.
REQ-019 SHALL implement POLL as repeated SR reads (adr 4, we=0) until SR[1] (TIP)=0.
REQ-020 SHALL, on POLL completion after any write byte, check SR[7] (RxACK) and SR[5] (AL); if either is 1, abort the sequence.
REQ-021 SHALL, on abort with AL=0, write CR=8'h40 (STO) and poll SR until SR[6] (BUSY)=0, then respond with rsp_nack=1; with AL=1, respond with rsp_nack=1 immediately without STO.
REQ-022 SHALL ignore RxACK after the final read byte (master NACK is intentional).
REQ-023 SHALL drive rsp_rdata=8'h00 on writes and on nack.
REQ-024 SHALL return to IDLE the cycle after rsp_valid; a request held valid is eligible for grant one cycle later.
REQ-025 SHALL hold req_valid changes during a transaction with no effect.
REQ-026 SHALL never assert stb without cyc, and never change adr/dat/we while stb=1 and ack=0.

Reset
REQ-027 SHALL, on RESET_N low (including mid-transaction), asynchronously clear all outputs to 0, set the state to INIT, and set the round-robin pointer so requester 0 wins; the init sequence SHALL rerun on release.

Structure
REQ-028 SHALL place core register addresses, CR command bytes (8'h90, 8'h10, 8'h50, 8'h68, 8'h40), SR bit indices, and the state enum in package i2c_seq_pkg.
REQ-029 SHALL factor the single-access handshake (REQ-012/013) into sub-module i2c_wb_access, with start/addr/wdata/we in and done/rdata out.

Verification
REQ-030 Reset release with a WB slave model -> writes 0x63@0, 0x00@1, 0x80@2 in order, busy high until done, no req_ready before.
REQ-031 Req0 write dev=0x51, reg=0x10, data=0xAC with an I2C slave ACKing -> TXR 0xA2, 0x10, 0xAC; CR 0x90, 0x10, 0x50; rsp_valid=2'b01, nack=0.
REQ-032 Req1 read dev=0x51, reg=0x20, slave returns 0x5A -> TXR 0xA2, 0x20, 0xA3; final CR 0x68; rsp_valid=2'b10, rdata=0x5A.
REQ-033 Write to absent dev 0x33 -> SR RxACK=1 after the first byte, CR=0x40 issued, nack=1, rdata=0x00.
REQ-034 Both requesters valid continuously for 4 transactions -> grants 0,1,0,1; no overlap of transactions.
REQ-035 RESET_N pulsed low during the second POLL -> outputs 0 immediately, init reruns, the pending request is regranted afterwards.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C transfer sequencer: OpenCores I2C master
// register addresses, CR command bytes, SR bit positions, sequencer states
// and the micro-op record the top level walks through.
package i2c_seq_pkg;

    // Core register map (TXR/RXR and CR/SR share addresses, split by we)
    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_RXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;
    localparam logic [2:0] ADR_SR     = 3'd4;

    // CR command bytes
    localparam logic [7:0] CR_STA_WR     = 8'h90;
    localparam logic [7:0] CR_WR         = 8'h10;
    localparam logic [7:0] CR_WR_STO     = 8'h50;
    localparam logic [7:0] CR_RD_ACK_STO = 8'h68;
    localparam logic [7:0] CR_STO        = 8'h40;

    // SR bit indices
    localparam int unsigned SR_RXACK = 7;
    localparam int unsigned SR_BUSY  = 6;
    localparam int unsigned SR_AL    = 5;
    localparam int unsigned SR_TIP   = 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_STOP,
        ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        OP_WR,
        OP_POLL_TIP,
        OP_POLL_BUSY,
        OP_RD,
        OP_END
    } op_e;

    // One step of a sequence; chk marks polls that follow a written byte
    typedef struct packed {
        op_e        kind;
        logic [2:0] adr;
        logic [7:0] dat;
        logic       chk;
    } op_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/i2c_xfer_sequencer_if.sv
// Bundle of the two-requester transaction handshake, completion response,
// busy flag and Wishbone master bus of i2c_xfer_sequencer.
//   master : sequencer side (drives req_ready, rsp_*, busy, wb_*_o)
//   slave  : requesters + Wishbone core side
interface i2c_xfer_sequencer_if;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_rnw;
    logic [1:0][6:0] req_dev;
    logic [1:0][7:0] req_reg;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic            rsp_nack;
    logic [7:0]      rsp_rdata;
    logic            busy;
    logic [2:0]      wb_adr_o;
    logic [7:0]      wb_dat_o;
    logic            wb_we_o;
    logic            wb_stb_o;
    logic            wb_cyc_o;
    logic [7:0]      wb_dat_i;
    logic            wb_ack_i;

    modport master (
        input  req_valid, req_rnw, req_dev, req_reg, req_wdata, wb_dat_i, wb_ack_i,
        output req_ready, rsp_valid, rsp_nack, rsp_rdata, busy,
               wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output req_valid, req_rnw, req_dev, req_reg, req_wdata, wb_dat_i, wb_ack_i,
        input  req_ready, rsp_valid, rsp_nack, rsp_rdata, busy,
               wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
    );
endinterface

// File: rtl/i2c_wb_access.sv
// Single Wishbone access engine.
//   start/addr/wdata/we : request one access (accepted only while idle)
//   done                : one-cycle pulse the cycle after wb_ack_i
//   rdata               : wb_dat_i captured on the ack cycle of a read
//   wb_*                : Wishbone master bus
module i2c_wb_access (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic       done,
    output logic [7:0] rdata,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);
    logic [2:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d;
    logic       we_q, we_d;
    logic       stb_q, stb_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;

    always_comb begin
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        stb_d   = stb_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        if (stb_q) begin
            if (wb_ack_i) begin
                stb_d  = 1'b0;
                done_d = 1'b1;
                if (!we_q) rdata_d = wb_dat_i;
            end
        end else if (start) begin
            adr_d = addr;
            dat_d = wdata;
            we_d  = we;
            stb_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Each cycle carries exactly one access, so cyc and stb share one flop
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = stb_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
endmodule

// File: rtl/i2c_xfer_sequencer.sv
// Two-requester I2C register transfer sequencer driving an OpenCores I2C
// master core over Wishbone. After reset it programs the prescaler and CTR,
// then grants requests round-robin and runs a full write or read register
// transaction, including STO recovery on a missing ACK.
//   CLOCK_50 : clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : requests/responses, busy and Wishbone master (master modport)
module i2c_xfer_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'h0063,
    parameter logic [7:0]  CTR_VAL  = 8'h80
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    i2c_xfer_sequencer_if.master  bus
);
    state_e     state_q;
    logic [3:0] step_q;
    logic       pend_q, start_q;
    logic [2:0] acc_adr_q;
    logic [7:0] acc_dat_q;
    logic       acc_we_q;
    logic       gnt_q, last_q;
    logic       rnw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q, wdata_q, rxr_q;
    logic [1:0] req_ready_q, rsp_valid_q;
    logic       rsp_nack_q, busy_q;
    logic [7:0] rsp_rdata_q;

    logic       acc_done;
    logic [7:0] acc_rdata;
    logic       gnt_sel;
    op_t        op;

    i2c_wb_access u_acc (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
        .start    (start_q),
        .addr     (acc_adr_q),
        .wdata    (acc_dat_q),
        .we       (acc_we_q),
        .done     (acc_done),
        .rdata    (acc_rdata),
        .wb_adr_o (bus.wb_adr_o),
        .wb_dat_o (bus.wb_dat_o),
        .wb_we_o  (bus.wb_we_o),
        .wb_stb_o (bus.wb_stb_o),
        .wb_cyc_o (bus.wb_cyc_o),
        .wb_dat_i (bus.wb_dat_i),
        .wb_ack_i (bus.wb_ack_i)
    );

    // Tie goes to the requester not granted last
    always_comb begin
        gnt_sel = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
    end

    // Sequence table: the current state selects the program, step_q the entry
    always_comb begin
        op = '{OP_END, 3'd0, 8'h00, 1'b0};
        unique case (state_q)
            ST_INIT: begin
                case (step_q)
                    4'd0: op = '{OP_WR, ADR_PRERLO, PRESCALE[7:0], 1'b0};
                    4'd1: op = '{OP_WR, ADR_PRERHI, PRESCALE[15:8], 1'b0};
                    4'd2: op = '{OP_WR, ADR_CTR, CTR_VAL, 1'b0};
                    default: ;
                endcase
            end
            ST_WRITE, ST_READ: begin
                case (step_q)
                    4'd0:  op = '{OP_WR, ADR_TXR, {dev_q, 1'b0}, 1'b0};
                    4'd1:  op = '{OP_WR, ADR_CR, CR_STA_WR, 1'b0};
                    4'd2:  op = '{OP_POLL_TIP, ADR_SR, 8'h00, 1'b1};
                    4'd3:  op = '{OP_WR, ADR_TXR, reg_q, 1'b0};
                    4'd4:  op = '{OP_WR, ADR_CR, CR_WR, 1'b0};
                    4'd5:  op = '{OP_POLL_TIP, ADR_SR, 8'h00, 1'b1};
                    4'd6:  op = '{OP_WR, ADR_TXR, rnw_q ? {dev_q, 1'b1} : wdata_q, 1'b0};
                    4'd7:  op = '{OP_WR, ADR_CR, rnw_q ? CR_STA_WR : CR_WR_STO, 1'b0};
                    4'd8:  op = '{OP_POLL_TIP, ADR_SR, 8'h00, 1'b1};
                    4'd9:  if (rnw_q) op = '{OP_WR, ADR_CR, CR_RD_ACK_STO, 1'b0};
                    // RxACK after the last read byte is our own NACK: no check
                    4'd10: if (rnw_q) op = '{OP_POLL_TIP, ADR_SR, 8'h00, 1'b0};
                    4'd11: if (rnw_q) op = '{OP_RD, ADR_RXR, 8'h00, 1'b0};
                    default: ;
                endcase
            end
            ST_STOP: begin
                case (step_q)
                    4'd0: op = '{OP_WR, ADR_CR, CR_STO, 1'b0};
                    4'd1: op = '{OP_POLL_BUSY, ADR_SR, 8'h00, 1'b0};
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_INIT;
            step_q      <= '0;
            pend_q      <= 1'b0;
            start_q     <= 1'b0;
            acc_adr_q   <= '0;
            acc_dat_q   <= '0;
            acc_we_q    <= 1'b0;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            rnw_q       <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            rxr_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_nack_q  <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid != 2'b00) begin
                        req_ready_q <= onehot2(gnt_sel);
                        gnt_q       <= gnt_sel;
                        last_q      <= gnt_sel;
                        rnw_q       <= bus.req_rnw[gnt_sel];
                        dev_q       <= bus.req_dev[gnt_sel];
                        reg_q       <= bus.req_reg[gnt_sel];
                        wdata_q     <= bus.req_wdata[gnt_sel];
                        busy_q      <= 1'b1;
                        step_q      <= '0;
                        state_q     <= bus.req_rnw[gnt_sel] ? ST_READ : ST_WRITE;
                    end
                end
                ST_RESP: begin
                    busy_q      <= 1'b0;
                    rsp_nack_q  <= 1'b0;
                    rsp_rdata_q <= '0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    if (state_q == ST_INIT) busy_q <= 1'b1;
                    if (!pend_q) begin
                        if (op.kind == OP_END) begin
                            if (state_q == ST_INIT) begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                rsp_valid_q <= onehot2(gnt_q);
                                rsp_nack_q  <= (state_q == ST_STOP);
                                rsp_rdata_q <= (state_q == ST_READ) ? rxr_q : 8'h00;
                                state_q     <= ST_RESP;
                            end
                        end else begin
                            start_q   <= 1'b1;
                            pend_q    <= 1'b1;
                            acc_adr_q <= op.adr;
                            acc_dat_q <= op.dat;
                            acc_we_q  <= (op.kind == OP_WR);
                        end
                    end else if (acc_done) begin
                        pend_q <= 1'b0;
                        unique case (op.kind)
                            OP_POLL_TIP: begin
                                if (!acc_rdata[SR_TIP]) begin
                                    if (op.chk && acc_rdata[SR_AL]) begin
                                        // Arbitration lost: the bus is not ours to stop
                                        rsp_valid_q <= onehot2(gnt_q);
                                        rsp_nack_q  <= 1'b1;
                                        rsp_rdata_q <= 8'h00;
                                        state_q     <= ST_RESP;
                                    end else if (op.chk && acc_rdata[SR_RXACK]) begin
                                        state_q <= ST_STOP;
                                        step_q  <= '0;
                                    end else begin
                                        step_q <= step_q + 4'd1;
                                    end
                                end
                            end
                            OP_POLL_BUSY: begin
                                if (!acc_rdata[SR_BUSY]) step_q <= step_q + 4'd1;
                            end
                            OP_RD: begin
                                rxr_q  <= acc_rdata;
                                step_q <= step_q + 4'd1;
                            end
                            default: step_q <= step_q + 4'd1;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_nack  = rsp_nack_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Directed bench for i2c_xfer_sequencer with a register-level model of the
// I2C master core (one wait state per access) and a single I2C slave at 0x51.
module tb_i2c_xfer_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    i2c_xfer_sequencer_if bus ();

    i2c_xfer_sequencer #(.PRESCALE(16'h0063), .CTR_VAL(8'h80)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- core register model ----------------
    logic [15:0] init_log[$];
    logic [7:0]  txr_log[$];
    logic [7:0]  cr_log[$];
    logic [7:0]  rxr_val;
    int          tip_cnt, busy_cnt, wait_cnt;
    int          proto_viol = 0;
    int          poll2_cnt  = 0;
    logic        rxack, held;
    logic [6:0]  cur_dev;
    logic [7:0]  txr_cur;
    logic [2:0]  h_adr;
    logic [7:0]  h_dat;
    logic        h_we;

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = 8'h00;
            held = 1'b0; wait_cnt = 0; tip_cnt = 0; busy_cnt = 0;
            rxack = 1'b0; cur_dev = '0; txr_cur = '0;
        end else if (bus.wb_ack_i) begin
            bus.wb_ack_i = 1'b0;
            held = 1'b0;
            if (bus.wb_stb_o) proto_viol++;
        end else if (bus.wb_stb_o) begin
            if (!bus.wb_cyc_o) proto_viol++;
            if (!held) begin
                held = 1'b1; wait_cnt = 0;
                h_adr = bus.wb_adr_o; h_dat = bus.wb_dat_o; h_we = bus.wb_we_o;
            end else if ({bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o} !== {h_adr, h_dat, h_we}) begin
                proto_viol++;
            end
            wait_cnt++;
            if (wait_cnt == 2) begin
                if (h_we) begin
                    if (h_adr <= 3'd2) init_log.push_back({5'b0, h_adr, h_dat});
                    else if (h_adr == 3'd3) begin
                        txr_log.push_back(h_dat);
                        txr_cur = h_dat;
                    end else if (h_adr == 3'd4) begin
                        cr_log.push_back(h_dat);
                        if (h_dat[7]) cur_dev = txr_cur[7:1];
                        if (h_dat[4]) begin tip_cnt = 2; rxack = (cur_dev != 7'h51); end
                        if (h_dat[5]) begin tip_cnt = 2; rxack = 1'b1; end
                        if (h_dat[6]) busy_cnt = 2;
                    end
                end else if (h_adr == 3'd3) begin
                    bus.wb_dat_i = rxr_val;
                end else begin
                    bus.wb_dat_i = {rxack, busy_cnt != 0, 1'b0, 3'b000, tip_cnt != 0, 1'b0};
                    if (tip_cnt > 0) tip_cnt--;
                    if (busy_cnt > 0) busy_cnt--;
                    if (cr_log.size() > 0 && cr_log[cr_log.size()-1] == 8'h10) poll2_cnt++;
                end
                bus.wb_ack_i = 1'b1;
            end
        end else if (bus.wb_cyc_o) begin
            proto_viol++;
        end
    end

    // ---------------- handshake monitor ----------------
    int         grant_cnt = 0;
    int         rsp_cnt = 0;
    int         overlap_viol = 0;
    logic       inflight = 1'b0;
    int         grant_log[$];
    int         grant_init_sz[$];
    logic [1:0] last_rv;
    logic       last_nack;
    logic [7:0] last_rdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            inflight = 1'b0;
        end else begin
            if (bus.req_ready != 2'b00) begin
                if (inflight || bus.req_ready == 2'b11) overlap_viol++;
                inflight = 1'b1;
                grant_cnt++;
                grant_log.push_back(int'(bus.req_ready[1]));
                grant_init_sz.push_back(init_log.size());
            end
            if (bus.rsp_valid != 2'b00) begin
                rsp_cnt++;
                last_rv = bus.rsp_valid;
                last_nack = bus.rsp_nack;
                last_rdata = bus.rsp_rdata;
                inflight = 1'b0;
            end
        end
    end

    task automatic do_req(input int idx, input logic rnw, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [7:0] wd);
        int g0, r0;
        g0 = grant_cnt;
        r0 = rsp_cnt;
        bus.req_rnw[idx]   = rnw;
        bus.req_dev[idx]   = dev;
        bus.req_reg[idx]   = rg;
        bus.req_wdata[idx] = wd;
        bus.req_valid[idx] = 1'b1;
        for (int n = 0; n < 3000 && grant_cnt == g0; n++) @(negedge clk);
        check("grant_timeout", grant_cnt > g0, 1);
        bus.req_valid[idx] = 1'b0;
        for (int n = 0; n < 3000 && rsp_cnt == r0; n++) @(negedge clk);
        check("rsp_timeout", rsp_cnt > r0, 1);
    endtask

    initial begin
        int tb0, cb0, gb, rb, ib, pb;
        logic busy_init_ok;

        bus.req_valid = 2'b00; bus.req_rnw = 2'b00;
        bus.req_dev = '0; bus.req_reg = '0; bus.req_wdata = '0;
        rxr_val = 8'h5A;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #4;
        check("reset_outputs",
              {bus.req_ready, bus.rsp_valid, bus.rsp_nack, bus.rsp_rdata, bus.busy,
               bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o, bus.wb_stb_o, bus.wb_cyc_o}, 0);

        // Request pending across init: it must not be granted before CTR is written
        bus.req_rnw[0] = 1'b0; bus.req_dev[0] = 7'h51;
        bus.req_reg[0] = 8'h10; bus.req_wdata[0] = 8'hAC;
        bus.req_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        busy_init_ok = 1'b1;
        for (int n = 0; n < 2000 && init_log.size() < 3; n++) begin
            @(negedge clk);
            if (init_log.size() > 0 && init_log.size() < 3) busy_init_ok &= bus.busy;
        end
        check("init_count", init_log.size(), 3);
        check("init_prerlo", init_log[0], 16'h0063);
        check("init_prerhi", init_log[1], 16'h0100);
        check("init_ctr", init_log[2], 16'h0280);
        check("init_busy", busy_init_ok, 1);

        // Write from requester 0 (held since reset)
        for (int n = 0; n < 3000 && grant_cnt == 0; n++) @(negedge clk);
        check("wr_grant_timeout", grant_cnt, 1);
        bus.req_valid[0] = 1'b0;
        for (int n = 0; n < 3000 && rsp_cnt == 0; n++) @(negedge clk);
        check("wr_rsp_timeout", rsp_cnt, 1);
        check("wr_grant_after_init", grant_init_sz[0], 3);
        check("wr_grant_idx", grant_log[0], 0);
        check("wr_txr", {txr_log[0], txr_log[1], txr_log[2]}, 24'hA210AC);
        check("wr_cr", {cr_log[0], cr_log[1], cr_log[2]}, 24'h901050);
        check("wr_rsp", {last_rv, last_nack, last_rdata}, {2'b01, 1'b0, 8'h00});

        // Read from requester 1
        tb0 = txr_log.size(); cb0 = cr_log.size();
        do_req(1, 1'b1, 7'h51, 8'h20, 8'h00);
        check("rd_txr", {txr_log[tb0], txr_log[tb0+1], txr_log[tb0+2]}, 24'hA220A3);
        check("rd_cr", {cr_log[cb0], cr_log[cb0+1], cr_log[cb0+2], cr_log[cb0+3]}, 32'h90109068);
        check("rd_rsp", {last_rv, last_nack, last_rdata}, {2'b10, 1'b0, 8'h5A});

        // Both requesters held valid: grants alternate
        gb = grant_cnt; rb = rsp_cnt;
        bus.req_rnw = 2'b00;
        bus.req_dev[0] = 7'h51; bus.req_reg[0] = 8'h01; bus.req_wdata[0] = 8'h11;
        bus.req_dev[1] = 7'h51; bus.req_reg[1] = 8'h02; bus.req_wdata[1] = 8'h22;
        bus.req_valid = 2'b11;
        for (int n = 0; n < 8000 && grant_cnt < gb + 4; n++) @(negedge clk);
        bus.req_valid = 2'b00;
        check("rr_grant_count", grant_cnt, gb + 4);
        for (int n = 0; n < 3000 && rsp_cnt < rb + 4; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("rr_rsp_count", rsp_cnt, rb + 4);
        check("rr_order", {grant_log[gb][0], grant_log[gb+1][0], grant_log[gb+2][0], grant_log[gb+3][0]}, 4'b0101);
        check("rr_overlap", overlap_viol, 0);

        // Absent device: NACK on address byte, STO issued
        tb0 = txr_log.size(); cb0 = cr_log.size();
        do_req(0, 1'b0, 7'h33, 8'h10, 8'h11);
        check("nack_txr_count", txr_log.size(), tb0 + 1);
        check("nack_txr", txr_log[tb0], 8'h66);
        check("nack_cr", {cr_log[cb0], cr_log[cb0+1]}, 16'h9040);
        check("nack_cr_count", cr_log.size(), cb0 + 2);
        check("nack_rsp", {last_rv, last_nack, last_rdata}, {2'b01, 1'b1, 8'h00});

        // Reset during the second poll; request stays pending
        pb = poll2_cnt;
        bus.req_rnw[0] = 1'b0; bus.req_dev[0] = 7'h51;
        bus.req_reg[0] = 8'h10; bus.req_wdata[0] = 8'hAC;
        bus.req_valid[0] = 1'b1;
        for (int n = 0; n < 3000 && poll2_cnt == pb; n++) @(negedge clk);
        check("poll2_timeout", poll2_cnt > pb, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {bus.req_ready, bus.rsp_valid, bus.rsp_nack, bus.rsp_rdata, bus.busy,
               bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o, bus.wb_stb_o, bus.wb_cyc_o}, 0);
        repeat (3) @(posedge clk);
        ib = init_log.size(); gb = grant_cnt; rb = rsp_cnt; tb0 = txr_log.size();
        #1 rst_n = 1'b1;
        for (int n = 0; n < 2000 && init_log.size() < ib + 3; n++) @(negedge clk);
        check("reinit", {init_log[ib], init_log[ib+1], init_log[ib+2]}, 48'h006301000280);
        for (int n = 0; n < 3000 && grant_cnt == gb; n++) @(negedge clk);
        check("regrant_timeout", grant_cnt, gb + 1);
        bus.req_valid[0] = 1'b0;
        for (int n = 0; n < 3000 && rsp_cnt == rb; n++) @(negedge clk);
        check("regrant_rsp_count", rsp_cnt, rb + 1);
        check("regrant_after_init", grant_init_sz[gb], ib + 3);
        check("regrant_txr", {txr_log[tb0], txr_log[tb0+1], txr_log[tb0+2]}, 24'hA210AC);
        check("regrant_rsp", {last_rv, last_nack, last_rdata}, {2'b01, 1'b0, 8'h00});

        repeat (10) @(negedge clk);
        check("wb_protocol", proto_viol, 0);
        check("no_overlap", overlap_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
